// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: serialises instruction-fetch and data accesses onto one
// byte-lane unified memory, data-first with a fetch anti-starvation counter.
module mem_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic [3:0]        dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_cs,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Handshake: a requester holds req and its payload stable until a one-cycle gnt;
    // req still high in the cycle after gnt is a fresh request. rvalid is a one-cycle
    // pulse with rdata valid alongside it; there is no back-pressure on read data.

    localparam int SC_W = $clog2(STARVE_MAX + 1);
    localparam int LC_W = $clog2(MEM_LAT + 1);
    localparam logic [SC_W-1:0] SC_MAX  = SC_W'(STARVE_MAX);
    localparam logic [LC_W-1:0] LAT_VAL = LC_W'(MEM_LAT);
    localparam logic [LC_W-1:0] LAT_ONE = LC_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [SC_W-1:0]   starve_cnt;
    logic [SC_W-1:0]   starve_nxt;
    logic [LC_W-1:0]   lat_cnt;
    logic [LC_W-1:0]   lat_nxt;

    logic              pick_dm;
    logic              take;
    logic              capture;

    logic              owner_dm_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;

    // Data wins a tie unless fetch has already been passed over STARVE_MAX times.
    always_comb begin
        pick_dm = 1'b0;
        if (dm_req && !(if_req && (starve_cnt == SC_MAX))) begin
            pick_dm = 1'b1;
        end
    end

    assign take    = (state == S_IDLE) && (if_req || dm_req);
    assign capture = (state == S_WAIT) && (lat_cnt == LAT_ONE);

    always_comb begin
        starve_nxt = starve_cnt;
        if (state == S_IDLE) begin
            if (!if_req) begin
                starve_nxt = '0;
            end else if (pick_dm) begin
                if (starve_cnt != SC_MAX) begin
                    starve_nxt = starve_cnt + SC_W'(1);
                end
            end else begin
                starve_nxt = '0;
            end
        end
    end

    always_comb begin
        lat_nxt = lat_cnt;
        case (state)
            S_ACCESS: lat_nxt = (we_q != 4'b0000) ? lat_cnt : LAT_VAL;
            S_WAIT:   lat_nxt = lat_cnt - LAT_ONE;
            default:  lat_nxt = lat_cnt;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            starve_cnt <= '0;
            lat_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            lat_cnt    <= lat_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (if_req || dm_req) state_nxt = S_ACCESS;
            S_ACCESS: state_nxt = (we_q != 4'b0000) ? S_IDLE : S_WAIT;
            S_WAIT:   if (lat_cnt == LAT_ONE) state_nxt = S_RESP;
            S_RESP:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Fetch is read-only, so its write enables and write data are latched as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_dm_q <= 1'b0;
            addr_q     <= '0;
            we_q       <= 4'b0000;
            wdata_q    <= '0;
        end else if (take) begin
            owner_dm_q <= pick_dm;
            addr_q     <= pick_dm ? dm_addr : if_addr;
            we_q       <= pick_dm ? dm_we : 4'b0000;
            wdata_q    <= pick_dm ? dm_wdata : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else if (capture) begin
            if (owner_dm_q) begin
                dm_rdata_q <= mem_rdata;
            end else begin
                if_rdata_q <= mem_rdata;
            end
        end
    end

    // Output decode: every output comes from state or latched registers only.
    always_comb begin
        mem_cs    = 1'b0;
        mem_we    = 4'b0000;
        if_gnt    = 1'b0;
        dm_gnt    = 1'b0;
        if_rvalid = 1'b0;
        dm_rvalid = 1'b0;
        case (state)
            S_ACCESS: begin
                mem_cs = 1'b1;
                mem_we = we_q;
                if_gnt = !owner_dm_q;
                dm_gnt = owner_dm_q;
            end
            S_RESP: begin
                if_rvalid = !owner_dm_q;
                dm_rvalid = owner_dm_q;
            end
            default: begin
                mem_cs = 1'b0;
            end
        endcase
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (read latency 1 and 3) each with a latency-exact
// memory model; a shadow memory feeds an expected-read queue checked on every rvalid.
module tb_mem_arbiter;

    localparam int AW   = 14;
    localparam int DW   = 32;
    localparam int LAT0 = 1;
    localparam int LAT1 = 3;
    localparam int NW   = 1 << AW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]         if_req;
    logic [1:0][AW-1:0] if_addr;
    logic [1:0]         if_gnt;
    logic [1:0]         if_rvalid;
    logic [1:0][DW-1:0] if_rdata;
    logic [1:0]         dm_req;
    logic [1:0][3:0]    dm_we;
    logic [1:0][AW-1:0] dm_addr;
    logic [1:0][DW-1:0] dm_wdata;
    logic [1:0]         dm_gnt;
    logic [1:0]         dm_rvalid;
    logic [1:0][DW-1:0] dm_rdata;
    logic [1:0]         mem_cs;
    logic [1:0][3:0]    mem_we;
    logic [1:0][AW-1:0] mem_addr;
    logic [1:0][DW-1:0] mem_wdata;

    int n_tests = 0;
    int n_fail  = 0;
    int rv_cnt [2];
    logic [DW+1:0] exp_q[$];
    logic [DW+1:0] sb_e;
    logic [DW-1:0] shadow [0:1][0:NW-1];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? LAT0 : LAT1;
        logic [DW-1:0] mem [0:NW-1];
        logic [DW-1:0] pipe [0:LAT1-1];

        initial begin
            for (int a = 0; a < NW; a++) mem[a] <= DW'(a);
        end

        // Read data appears exactly LAT cycles after the chip-select cycle; filler otherwise.
        always @(posedge clk) begin
            if (mem_cs[g]) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_we[g][b]) mem[mem_addr[g]][8*b +: 8] <= mem_wdata[g][8*b +: 8];
                end
                pipe[0] <= mem[mem_addr[g]];
            end else begin
                pipe[0] <= 32'hA5A5_A5A5;
            end
            for (int s = 1; s < LAT1; s++) pipe[s] <= pipe[s-1];
        end

        mem_arbiter #(
            .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(4)
        ) u_dut (
            .clk(clk), .rst(rst),
            .if_req(if_req[g]), .if_addr(if_addr[g]), .if_gnt(if_gnt[g]),
            .if_rvalid(if_rvalid[g]), .if_rdata(if_rdata[g]),
            .dm_req(dm_req[g]), .dm_we(dm_we[g]), .dm_addr(dm_addr[g]),
            .dm_wdata(dm_wdata[g]), .dm_gnt(dm_gnt[g]),
            .dm_rvalid(dm_rvalid[g]), .dm_rdata(dm_rdata[g]),
            .mem_cs(mem_cs[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
            .mem_wdata(mem_wdata[g]), .mem_rdata(pipe[LAT-1])
        );
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every rvalid pops one {instance, port, data} entry.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (if_gnt[k] || dm_gnt[k]) check("gnt_excl", 64'(if_gnt[k] & dm_gnt[k]), 0);
            if (if_rvalid[k] || dm_rvalid[k]) begin
                rv_cnt[k]++;
                check("rvalid_excl", 64'(if_rvalid[k] & dm_rvalid[k]), 0);
                if (exp_q.size() == 0) begin
                    check("rvalid_unexpected", 64'({if_rvalid[k], dm_rvalid[k]}), 0);
                end else begin
                    sb_e = exp_q.pop_front();
                    check("sb_rdata",
                          64'({k[0], dm_rvalid[k], dm_rvalid[k] ? dm_rdata[k] : if_rdata[k]}),
                          64'(sb_e));
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge of the grant cycle with req dropped.
    task automatic do_req(input int k, input bit dm, input logic [3:0] we,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          output int cyc);
        bit seen;
        if (dm) begin
            dm_req[k] = 1'b1; dm_we[k] = we; dm_addr[k] = addr; dm_wdata[k] = wdata;
        end else begin
            if_req[k] = 1'b1; if_addr[k] = addr;
        end
        if (dm && we != 4'b0000) begin
            for (int b = 0; b < 4; b++) begin
                if (we[b]) shadow[k][addr][8*b +: 8] = wdata[8*b +: 8];
            end
        end else begin
            exp_q.push_back({k[0], dm, shadow[k][addr]});
        end
        cyc = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            cyc++;
            if (dm ? dm_gnt[k] : if_gnt[k]) seen = 1'b1;
        end
        if (dm) dm_req[k] = 1'b0; else if_req[k] = 1'b0;
        check("gnt_seen", 64'(seen), 1);
    endtask

    task automatic wait_rvalid(input int k, input bit dm, output int cyc, output logic [DW-1:0] data);
        bit seen;
        cyc = 0;
        seen = 1'b0;
        data = '0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            cyc++;
            if (dm ? dm_rvalid[k] : if_rvalid[k]) begin
                seen = 1'b1;
                data = dm ? dm_rdata[k] : if_rdata[k];
            end
        end
        check("rvalid_seen", 64'(seen), 1);
    endtask

    initial begin
        int c;
        int n;
        int snap;
        logic [DW-1:0] d;
        bit exp_d [10];
        bit dm;
        logic [3:0] we;
        logic [AW-1:0] addr;

        rst = 1'b1;
        if_req = '0; if_addr = '0;
        dm_req = '0; dm_we = '0; dm_addr = '0; dm_wdata = '0;
        rv_cnt[0] = 0; rv_cnt[1] = 0;
        for (int k = 0; k < 2; k++) for (int a = 0; a < NW; a++) shadow[k][a] = DW'(a);
        exp_d = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

        @(negedge clk);
        @(negedge clk);
        check("rst_cs", 64'(mem_cs), 0);
        check("rst_we", 64'(mem_we), 0);
        check("rst_gnt", 64'({if_gnt, dm_gnt}), 0);
        check("rst_rvalid", 64'({if_rvalid, dm_rvalid}), 0);
        check("rst_rdata0", {if_rdata[0], dm_rdata[0]}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single fetch read, latency 1
        if_req[0] = 1'b1; if_addr[0] = 14'h0010;
        exp_q.push_back({1'b0, 1'b0, 32'h0000_0010});
        @(negedge clk);
        check("f1_cs", 64'(mem_cs[0]), 1);
        check("f1_gnt", 64'(if_gnt[0]), 1);
        check("f1_addr", 64'(mem_addr[0]), 64'h10);
        check("f1_we", 64'(mem_we[0]), 0);
        if_req[0] = 1'b0;
        @(negedge clk);
        check("f1_rv_early", 64'(if_rvalid[0]), 0);
        @(negedge clk);
        check("f1_rvalid", 64'(if_rvalid[0]), 1);
        check("f1_rdata", 64'(if_rdata[0]), 64'h10);
        @(negedge clk);

        // Partial data write, then an immediate read proves IDLE at T0+2
        do_req(0, 1'b1, 4'b0011, 14'h2000, 32'hDEAD_BEEF, c);
        check("pw_gnt_lat", 64'(c), 1);
        check("pw_mem_we", 64'(mem_we[0]), 64'b0011);
        check("pw_mem_addr", 64'(mem_addr[0]), 64'h2000);
        check("pw_mem_wdata", 64'(mem_wdata[0]), 64'hDEAD_BEEF);
        do_req(0, 1'b1, 4'b0000, 14'h2000, 32'h0, c);
        check("pw_idle_t2", 64'(c), 2);
        wait_rvalid(0, 1'b1, c, d);
        check("pw_rd_lat", 64'(c), LAT0 + 1);
        check("pw_low_half", 64'(d[15:0]), 64'hBEEF);
        repeat (3) @(negedge clk);

        // Anti-starvation: both requesters held high
        dm_req[0] = 1'b1; dm_we[0] = 4'hF; dm_addr[0] = 14'h0100; dm_wdata[0] = 32'h1234_5678;
        shadow[0][14'h0100] = 32'h1234_5678;
        if_req[0] = 1'b1; if_addr[0] = 14'h0020;
        n = 0;
        for (int i = 0; i < 200 && n < 10; i++) begin
            @(negedge clk);
            if (if_gnt[0] || dm_gnt[0]) begin
                check($sformatf("starve_gnt%0d", n), 64'({if_gnt[0], dm_gnt[0]}),
                      exp_d[n] ? 64'b01 : 64'b10);
                if (if_gnt[0]) exp_q.push_back({1'b0, 1'b0, shadow[0][14'h0020]});
                n++;
                if (n == 10) begin
                    if_req[0] = 1'b0;
                    dm_req[0] = 1'b0;
                end
            end
        end
        check("starve_count", 64'(n), 10);
        repeat (5) @(negedge clk);
        check("starve_q_empty", 64'(exp_q.size()), 0);

        // Random traffic on the latency-1 instance
        for (int t = 0; t < 16; t++) begin
            @(negedge clk);
            dm = 1'($urandom_range(0, 1));
            addr = 14'($urandom_range(0, 31));
            we = (dm && $urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
            do_req(0, dm, we, addr, $urandom(), c);
            check("rnd_gnt_lat", 64'(c), 1);
            if (we == 4'b0000) begin
                wait_rvalid(0, dm, c, d);
                check("rnd_rd_lat", 64'(c), LAT0 + 1);
            end
        end
        repeat (2) @(negedge clk);

        // Long latency: data read at T0, fetch raised at T0+2
        dm_req[1] = 1'b1; dm_we[1] = 4'b0000; dm_addr[1] = 14'h0040;
        exp_q.push_back({1'b1, 1'b1, 32'h0000_0040});
        @(negedge clk);
        check("ll_dm_gnt", 64'(dm_gnt[1]), 1);
        dm_req[1] = 1'b0;
        @(negedge clk);
        if_req[1] = 1'b1; if_addr[1] = 14'h0050;
        exp_q.push_back({1'b1, 1'b0, 32'h0000_0050});
        @(negedge clk);
        check("ll_rv_t3", 64'(dm_rvalid[1]), 0);
        @(negedge clk);
        check("ll_rv_t4", 64'(dm_rvalid[1]), 0);
        @(negedge clk);
        check("ll_rv_t5", 64'(dm_rvalid[1]), 1);
        check("ll_rdata_t5", 64'(dm_rdata[1]), 64'h40);
        check("ll_ifgnt_t5", 64'(if_gnt[1]), 0);
        @(negedge clk);
        check("ll_ifgnt_t6", 64'(if_gnt[1]), 0);
        @(negedge clk);
        check("ll_ifgnt_t7", 64'(if_gnt[1]), 1);
        if_req[1] = 1'b0;
        wait_rvalid(1, 1'b0, c, d);
        check("ll_if_rd_lat", 64'(c), LAT1 + 1);
        check("ll_if_rdata", 64'(d), 64'h50);
        @(negedge clk);

        // Reset during WAIT: read is discarded
        dm_req[1] = 1'b1; dm_we[1] = 4'b0000; dm_addr[1] = 14'h0060;
        @(negedge clk);
        check("rw_gnt", 64'(dm_gnt[1]), 1);
        dm_req[1] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rw_cs", 64'(mem_cs), 0);
        check("rw_we", 64'(mem_we), 0);
        check("rw_addr", 64'(mem_addr), 0);
        check("rw_wdata", 64'(mem_wdata), 0);
        check("rw_gnt_rv", 64'({if_gnt, dm_gnt, if_rvalid, dm_rvalid}), 0);
        check("rw_rdata0", {if_rdata[0], dm_rdata[0]}, 0);
        check("rw_rdata1", {if_rdata[1], dm_rdata[1]}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        snap = rv_cnt[1];
        repeat (8) @(negedge clk);
        check("rw_no_rvalid", 64'(rv_cnt[1] - snap), 0);
        do_req(1, 1'b0, 4'b0000, 14'h0070, 32'h0, c);
        check("rw_fetch_gnt", 64'(c), 1);
        wait_rvalid(1, 1'b0, c, d);
        check("rw_fetch_lat", 64'(c), LAT1 + 1);
        check("rw_fetch_data", 64'(d), 64'h70);
        @(negedge clk);

        // End marker: full-word write at the top address and read back
        do_req(0, 1'b1, 4'b1111, 14'h3fff, 32'hFFFF_FFFF, c);
        check("em_gnt_lat", 64'(c), 1);
        check("em_mem_addr", 64'(mem_addr[0]), 64'h3fff);
        @(negedge clk);
        do_req(0, 1'b1, 4'b0000, 14'h3fff, 32'h0, c);
        wait_rvalid(0, 1'b1, c, d);
        check("em_readback", 64'(d), 64'hFFFF_FFFF);

        repeat (3) @(negedge clk);
        check("final_q_empty", 64'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter that lets the CPU's instruction-fetch port and data-access port share one byte-lane unified memory (word-addressed, four byte lanes). It sits between `i_CPU` and the memory inside `top`. It serialises accesses with a small FSM, applies fixed data-first priority with a fetch anti-starvation counter, and returns read data with a fixed, parameterised latency.

## Interface
- `ADDR_W`, 14, word-address width; covers 0x0000–0x3fff.
- `DATA_W`, 32, data width; four 8-bit byte lanes.
- `MEM_LAT`, 1, memory read latency in cycles, ≥1.
- `STARVE_MAX`, 4, maximum consecutive data grants while a fetch is pending.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `if_req`  in  1  fetch request, read-only.
- `if_addr`  in  ADDR_W  fetch word address.
- `if_gnt`  out  1  fetch grant pulse.
- `if_rvalid`  out  1  fetch read-data valid pulse.
- `if_rdata`  out  DATA_W  fetch read data.
- `dm_req`  in  1  data request.
- `dm_we`  in  4  byte write enables; 4'b0000 means read.
- `dm_addr`  in  ADDR_W  data word address.
- `dm_wdata`  in  DATA_W  write data.
- `dm_gnt`  out  1  data grant pulse.
- `dm_rvalid`  out  1  data read-data valid pulse.
- `dm_rdata`  out  DATA_W  data read data.
- `mem_cs`  out  1  memory chip select, one cycle per access.
- `mem_we`  out  4  memory byte write enables, active-high.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data, valid MEM_LAT cycles after the `mem_cs` cycle.

## Operation
- FSM states are IDLE, ACCESS, WAIT and RESP. Only one access is outstanding at a time.
- **IDLE:** samples `if_req` and `dm_req`.
  - If either is high, latch the winner's owner, address, `we` and `wdata`, then go to ACCESS.
  - If neither is high, stay in IDLE.
- **Arbitration:**
  - If only one requester is active, that requester wins.
  - If both are active, data wins unless `starve_cnt == STARVE_MAX`; in that case fetch wins.
- **starve_cnt** has width `$clog2(STARVE_MAX+1)` and resets to 0.
  - Increments when data wins while `if_req` is high.
  - Clears when fetch wins, or in any IDLE cycle with `if_req` low.
  - Never exceeds STARVE_MAX.
- **ACCESS:**
  - Drives `mem_cs=1`, `mem_addr`, `mem_wdata` and `mem_we` from the latched values; `mem_we` is forced to 0 for fetch.
  - Pulses the owner's `gnt`.
  - Write: next state IDLE.
  - Read: next state WAIT, with `lat_cnt` loaded to MEM_LAT.
- **WAIT:**
  - Decrements `lat_cnt` each cycle.
  - In the cycle where `lat_cnt == 1`, captures `mem_rdata` into the owner's `rdata` register and goes to RESP.
- **RESP:** pulses the owner's `rvalid` for one cycle while `rdata` holds the captured value, then goes to IDLE.
- Write requests never produce `rvalid`.
- **Requester rule:**
  - Hold `req`, `addr`, `we` and `wdata` stable from assertion until `gnt`.
  - If `req` is still high in the cycle after `gnt`, it is a new request.
  - Requests raised outside IDLE wait; they are not lost.
- All outputs are decoded from registers only. There is no combinational path from any input to any output.
- `if_rdata` and `dm_rdata` hold their last captured value until overwritten.

## Timing
- **Reset:** asserting `rst` immediately, asynchronously, forces all of the following:
  - FSM to IDLE;
  - `starve_cnt` and `lat_cnt` to 0;
  - `mem_cs`, `mem_we`, `mem_addr`, `mem_wdata`, both `gnt`, both `rvalid` and both `rdata` to 0.
- **Reset mid-access:** a read in WAIT or RESP is discarded, and no `rvalid` is issued after release.
- **Read latency:** with `req` sampled in IDLE cycle T0:
  - `gnt` and `mem_cs` occur in T0+1;
  - `rvalid` occurs in T0+MEM_LAT+2.
- **Write latency:** `gnt`, `mem_cs` and `mem_we` occur in T0+1, and the FSM is in IDLE at T0+2.
- **Throughput:**
  - Back-to-back writes: one access per 2 cycles.
  - Back-to-back reads: one access per MEM_LAT+3 cycles.
- **Simultaneous events:**
  - Requests arriving in ACCESS, WAIT or RESP are arbitrated at the next IDLE.
  - Both `gnt` and both `rvalid` are never high in the same cycle.

## Test plan
- **Single fetch read:**
  - Stimulus: MEM_LAT=1; `if_req=1`, `if_addr=0x0010` at T0; memory model returns `{18'b0, addr}`.
  - Required response: `mem_cs`, `if_gnt` and `mem_addr=0x0010` with `mem_we=0` at T0+1; `if_rvalid=1` with `if_rdata=0x00000010` at T0+3.
- **Partial data write:**
  - Stimulus: `dm_we=4'b0011`, `dm_addr=0x2000`, `dm_wdata=0xDEADBEEF`.
  - Required response: `mem_we=4'b0011` and `dm_gnt` at T0+1; `dm_rvalid` never asserts; back in IDLE at T0+2; low half-word of 0x2000 reads back as 0xBEEF.
- **Anti-starvation:**
  - Stimulus: `if_req` and `dm_req` (writes) held high continuously, STARVE_MAX=4.
  - Required response: grant sequence D,D,D,D,I,D,D,D,D,I; `starve_cnt` never exceeds 4.
- **Long latency:**
  - Stimulus: MEM_LAT=3; `dm` read at T0; `if_req` raised at T0+2.
  - Required response: `dm_rvalid` at T0+5; `if_gnt` at T0+7.
- **Reset during WAIT:**
  - Stimulus: MEM_LAT=3; assert `rst` at T0+2 of a read.
  - Required response: all outputs are 0 at once; no `rvalid` after release; a subsequent fetch completes normally.
- **End marker:**
  - Stimulus: data write of 0xFFFFFFFF to 0x3fff with `dm_we=4'b1111`.
  - Required response: the memory word at 0x3fff reads back as 0xFFFFFFFF.
